// File: rtl/tp_sequence_monitor.sv
// tp_sequence_monitor: receive-side checker for the timer time pulses T01..T12.
// Tracks the T01->T12 succession, counts completed memory cycles, and flags
// out-of-order, multi-edge and (optionally) stall faults.
// Optional stall watchdog is compiled in when TPMON_WATCHDOG_EN is defined.
module tp_sequence_monitor #(
    parameter int unsigned MCT_W      = 16,
    parameter int unsigned ERR_W      = 8,
    parameter int unsigned MAX_ERR    = 4,
    parameter int unsigned WDOG_LIMIT = 200
) (
    input  logic             SIM_CLK,
    input  logic             SIM_RST_,
    input  logic             T01,
    input  logic             T02,
    input  logic             T03,
    input  logic             T04,
    input  logic             T05,
    input  logic             T06,
    input  logic             T07,
    input  logic             T08,
    input  logic             T09,
    input  logic             T10,
    input  logic             T11,
    input  logic             T12,
    input  logic             STOP,
    input  logic             GOJAM,
    input  logic             CLR,
    output logic [3:0]       TPIDX,
    output logic             LOCKED,
    output logic             MCT_STB,
    output logic [MCT_W-1:0] MCT_CNT,
    output logic             SEQ_ERR,
    output logic             OHOT_ERR,
    output logic             WDOG_ERR,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             FAULT
);

    localparam int unsigned NT = 12;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [NT-1:0]    t_c;
    logic [NT-1:0]    t_d_q;
    logic [NT-1:0]    edge_c;
    logic             multi_edge_c;
    logic [3:0]       edge_idx_c;
    logic [3:0]       exp_idx_c;
    logic             err_event_c;

    logic [3:0]       tpidx_q, tpidx_d;
    logic             mct_stb_q, mct_stb_d;
    logic [MCT_W-1:0] mct_cnt_q, mct_cnt_d;
    logic             seq_err_q, seq_err_d;
    logic             ohot_err_q, ohot_err_d;
    logic             wdog_err_q, wdog_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             locked_c, fault_c;

`ifdef TPMON_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
`else
    logic unused_wdog;
    assign unused_wdog = STOP | (WDOG_LIMIT == 0);
`endif

    assign t_c          = {T12, T11, T10, T09, T08, T07, T06, T05, T04, T03, T02, T01};
    assign edge_c       = t_c & ~t_d_q;
    assign multi_edge_c = |(edge_c & (edge_c - NT'(1)));
    assign exp_idx_c    = (tpidx_q == 4'd12) ? 4'd1 : tpidx_q + 4'd1;

    // Index (1..12) of the single rising edge, 0 when none.
    always_comb begin
        edge_idx_c = 4'd0;
        for (int i = 0; i < NT; i++) begin
            if (edge_c[i]) edge_idx_c = 4'(i + 1);
        end
    end

    // State register.
    always_ff @(posedge SIM_CLK or negedge SIM_RST_) begin
        if (!SIM_RST_) state_q <= ST_SYNC;
        else           state_q <= state_d;
    end

    // Next-state and datapath: CLR > GOJAM > edge processing > watchdog.
    always_comb begin
        state_d     = state_q;
        tpidx_d     = tpidx_q;
        mct_stb_d   = 1'b0;
        mct_cnt_d   = mct_cnt_q;
        seq_err_d   = seq_err_q;
        ohot_err_d  = ohot_err_q;
        wdog_err_d  = wdog_err_q;
        err_cnt_d   = err_cnt_q;
        err_event_c = 1'b0;
`ifdef TPMON_WATCHDOG_EN
        wdog_d      = wdog_q;
`endif
        if (CLR) begin
            state_d    = ST_SYNC;
            tpidx_d    = 4'd0;
            mct_cnt_d  = '0;
            seq_err_d  = 1'b0;
            ohot_err_d = 1'b0;
            wdog_err_d = 1'b0;
            err_cnt_d  = '0;
`ifdef TPMON_WATCHDOG_EN
            wdog_d     = '0;
`endif
        end else if (state_q == ST_FAULT) begin
            state_d = ST_FAULT;
        end else if (GOJAM) begin
            state_d = ST_SYNC;
            tpidx_d = 4'd0;
`ifdef TPMON_WATCHDOG_EN
            wdog_d  = '0;
`endif
        end else if (multi_edge_c) begin
            ohot_err_d  = 1'b1;
            err_event_c = 1'b1;
            state_d     = ST_SYNC;
            tpidx_d     = 4'd0;
        end else if (edge_idx_c != 4'd0) begin
            if (state_q == ST_SYNC) begin
                if (edge_idx_c == 4'd1) begin
                    state_d = ST_RUN;
                    tpidx_d = 4'd1;
`ifdef TPMON_WATCHDOG_EN
                    wdog_d  = '0;
`endif
                end
            end else if (edge_idx_c == exp_idx_c) begin
                tpidx_d = edge_idx_c;
`ifdef TPMON_WATCHDOG_EN
                wdog_d  = '0;
`endif
                if (edge_idx_c == 4'd1) begin
                    mct_stb_d = 1'b1;
                    mct_cnt_d = mct_cnt_q + MCT_W'(1);
                end
            end else begin
                seq_err_d   = 1'b1;
                err_event_c = 1'b1;
                state_d     = ST_SYNC;
                tpidx_d     = 4'd0;
            end
        end else if (state_q == ST_RUN) begin
`ifdef TPMON_WATCHDOG_EN
            if (!STOP) begin
                if (wdog_q == WDOG_W'(WDOG_LIMIT - 1)) begin
                    wdog_err_d  = 1'b1;
                    err_event_c = 1'b1;
                    state_d     = ST_SYNC;
                    tpidx_d     = 4'd0;
                    wdog_d      = '0;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
`endif
        end

        // Several sources in one cycle count once; reaching MAX_ERR latches FAULT.
        if (err_event_c) begin
            err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_W'(1);
            if (32'(err_cnt_d) >= MAX_ERR) begin
                state_d = ST_FAULT;
                tpidx_d = 4'd0;
            end
        end
    end

    // Output decode from the registered state.
    always_comb begin
        locked_c = 1'b0;
        fault_c  = 1'b0;
        case (state_q)
            ST_RUN:   locked_c = 1'b1;
            ST_FAULT: fault_c  = 1'b1;
            default:  ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge SIM_CLK or negedge SIM_RST_) begin
        if (!SIM_RST_) begin
            t_d_q      <= '0;
            tpidx_q    <= 4'd0;
            mct_stb_q  <= 1'b0;
            mct_cnt_q  <= '0;
            seq_err_q  <= 1'b0;
            ohot_err_q <= 1'b0;
            wdog_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            t_d_q      <= t_c;
            tpidx_q    <= tpidx_d;
            mct_stb_q  <= mct_stb_d;
            mct_cnt_q  <= mct_cnt_d;
            seq_err_q  <= seq_err_d;
            ohot_err_q <= ohot_err_d;
            wdog_err_q <= wdog_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

`ifdef TPMON_WATCHDOG_EN
    // Stall watchdog counter.
    always_ff @(posedge SIM_CLK or negedge SIM_RST_) begin
        if (!SIM_RST_) wdog_q <= '0;
        else           wdog_q <= wdog_d;
    end
`endif

    assign TPIDX    = tpidx_q;
    assign LOCKED   = locked_c;
    assign FAULT    = fault_c;
    assign MCT_STB  = mct_stb_q;
    assign MCT_CNT  = mct_cnt_q;
    assign SEQ_ERR  = seq_err_q;
    assign OHOT_ERR = ohot_err_q;
    assign WDOG_ERR = wdog_err_q;
    assign ERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_tp_sequence_monitor.sv
// Bench for tp_sequence_monitor: directed scenarios plus randomized pulse
// traffic, every cycle compared against a behavioural model of the monitor.
module tb_tp_sequence_monitor;

`ifdef TPMON_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif
    localparam int WDOG_LIMIT = 200;
    localparam int MAX_ERR    = 4;

    logic        clk;
    logic        rst_n;
    logic [12:1] t_vec;
    logic        stop, gojam, clr;
    logic [3:0]  TPIDX;
    logic        LOCKED, MCT_STB, SEQ_ERR, OHOT_ERR, WDOG_ERR, FAULT;
    logic [15:0] MCT_CNT;
    logic [7:0]  ERR_CNT;

    int n_cmp  = 0;
    int n_fail = 0;
    int stb_seen = 0;

    // Behavioural model state.
    bit          m_locked, m_fault, m_stb, m_seq, m_ohot, m_wd;
    int          m_idx, m_mct, m_err, m_wdog;
    logic [12:1] m_prev;

    tp_sequence_monitor dut (
        .SIM_CLK (clk),
        .SIM_RST_(rst_n),
        .T01(t_vec[1]), .T02(t_vec[2]), .T03(t_vec[3]),  .T04(t_vec[4]),
        .T05(t_vec[5]), .T06(t_vec[6]), .T07(t_vec[7]),  .T08(t_vec[8]),
        .T09(t_vec[9]), .T10(t_vec[10]), .T11(t_vec[11]), .T12(t_vec[12]),
        .STOP    (stop),
        .GOJAM   (gojam),
        .CLR     (clr),
        .TPIDX   (TPIDX),
        .LOCKED  (LOCKED),
        .MCT_STB (MCT_STB),
        .MCT_CNT (MCT_CNT),
        .SEQ_ERR (SEQ_ERR),
        .OHOT_ERR(OHOT_ERR),
        .WDOG_ERR(WDOG_ERR),
        .ERR_CNT (ERR_CNT),
        .FAULT   (FAULT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("TPIDX",    32'(TPIDX),    32'(m_locked ? m_idx : 0));
        chk("LOCKED",   32'(LOCKED),   32'(m_locked));
        chk("MCT_STB",  32'(MCT_STB),  32'(m_stb));
        chk("MCT_CNT",  32'(MCT_CNT),  32'(m_mct));
        chk("SEQ_ERR",  32'(SEQ_ERR),  32'(m_seq));
        chk("OHOT_ERR", 32'(OHOT_ERR), 32'(m_ohot));
        chk("WDOG_ERR", 32'(WDOG_ERR), 32'(m_wd));
        chk("ERR_CNT",  32'(ERR_CNT),  32'(m_err));
        chk("FAULT",    32'(FAULT),    32'(m_fault));
    endtask

    // One clock of the monitor's rules, evaluated on the inputs seen at the edge.
    task automatic model_step();
        logic [12:1] e;
        int n, k;
        bit err;
        e = t_vec & ~m_prev;
        m_prev = t_vec;
        n = $countones(e);
        k = 0;
        err = 1'b0;
        m_stb = 1'b0;
        for (int i = 1; i <= 12; i++) if (e[i]) k = i;
        if (clr) begin
            m_locked = 0; m_fault = 0; m_idx = 0; m_mct = 0;
            m_seq = 0; m_ohot = 0; m_wd = 0; m_err = 0; m_wdog = 0;
        end else if (m_fault) begin
            m_locked = 0;
        end else if (gojam) begin
            m_locked = 0; m_idx = 0; m_wdog = 0;
        end else if (n > 1) begin
            m_ohot = 1; err = 1; m_locked = 0; m_idx = 0;
        end else if (n == 1) begin
            if (!m_locked) begin
                if (k == 1) begin m_locked = 1; m_idx = 1; m_wdog = 0; end
            end else if (k == (m_idx % 12) + 1) begin
                if (k == 1) begin
                    m_stb = 1;
                    m_mct = (m_mct + 1) % 65536;
                end
                m_idx = k;
                m_wdog = 0;
            end else begin
                m_seq = 1; err = 1; m_locked = 0; m_idx = 0;
            end
        end else if (m_locked && WD_EN && !stop) begin
            m_wdog++;
            if (m_wdog >= WDOG_LIMIT) begin
                m_wd = 1; err = 1; m_locked = 0; m_idx = 0; m_wdog = 0;
            end
        end
        if (err) begin
            if (m_err < 255) m_err++;
            if (m_err >= MAX_ERR) begin m_fault = 1; m_locked = 0; m_idx = 0; end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (MCT_STB === 1'b1) stb_seen++;
        check_all();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input int k, input int gap);
        t_vec[k] = 1'b1;
        tick();
        t_vec[k] = 1'b0;
        ticks(gap - 1);
    endtask

    task automatic pulse2(input int a, input int b, input int gap);
        t_vec[a] = 1'b1;
        t_vec[b] = 1'b1;
        tick();
        t_vec = '0;
        ticks(gap - 1);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int r, a, b, nxt;
        rst_n = 1'b0; t_vec = '0; stop = 1'b0; gojam = 1'b0; clr = 1'b0;
        m_locked = 0; m_fault = 0; m_stb = 0; m_seq = 0; m_ohot = 0; m_wd = 0;
        m_idx = 0; m_mct = 0; m_err = 0; m_wdog = 0; m_prev = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_TPIDX",  32'(TPIDX),   0);
        chk("rst_LOCKED", 32'(LOCKED),  0);
        chk("rst_STB",    32'(MCT_STB), 0);
        chk("rst_MCT",    32'(MCT_CNT), 0);
        chk("rst_ERRS",   32'({SEQ_ERR, OHOT_ERR, WDOG_ERR}), 0);
        chk("rst_ERRCNT", 32'(ERR_CNT), 0);
        chk("rst_FAULT",  32'(FAULT),   0);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(2);

        // A non-T01 edge in SYNC is ignored silently.
        pulse(5, 10);
        chk("sync_ignore_LOCKED", 32'(LOCKED), 0);
        chk("sync_ignore_ERR",    32'(ERR_CNT), 0);

        // Three clean rounds at 50-cycle spacing.
        stb_seen = 0;
        for (int rd = 0; rd < 3; rd++) begin
            for (int k = 1; k <= 12; k++) begin
                pulse(k, 50);
                chk("round_TPIDX", 32'(TPIDX), 32'(k));
            end
        end
        chk("rounds_STB_count", 32'(stb_seen), 2);
        chk("rounds_MCT",       32'(MCT_CNT),  2);
        chk("rounds_ERR",       32'(ERR_CNT),  0);
        chk("rounds_LOCKED",    32'(LOCKED),   1);

        // Sequence error: T07 after T05.
        do_clr();
        for (int k = 1; k <= 5; k++) pulse(k, 20);
        pulse(7, 20);
        chk("seq_SEQ",    32'(SEQ_ERR), 1);
        chk("seq_ERRCNT", 32'(ERR_CNT), 1);
        chk("seq_TPIDX",  32'(TPIDX),   0);
        chk("seq_LOCKED", 32'(LOCKED),  0);
        pulse(1, 20);
        chk("relock_TPIDX", 32'(TPIDX),   1);
        chk("relock_MCT",   32'(MCT_CNT), 0);

        // One-hot violation: T03 and T04 together.
        do_clr();
        pulse(1, 10);
        pulse(2, 10);
        pulse2(3, 4, 10);
        chk("ohot_OHOT",   32'(OHOT_ERR), 1);
        chk("ohot_SEQ",    32'(SEQ_ERR),  0);
        chk("ohot_ERRCNT", 32'(ERR_CNT),  1);

        // Stall after T06 with STOP low.
        do_clr();
        for (int k = 1; k <= 5; k++) pulse(k, 50);
        pulse(6, 200);
        chk("wdog_before_limit", 32'(WDOG_ERR), 0);
        tick();
        chk("wdog_at_limit", 32'(WDOG_ERR), 32'(WD_EN));
        // Long stall with STOP high: no error, T07 accepted.
        do_clr();
        for (int k = 1; k <= 6; k++) pulse(k, 20);
        stop = 1'b1;
        ticks(1000);
        chk("stop_WDOG",   32'(WDOG_ERR), 0);
        chk("stop_LOCKED", 32'(LOCKED),   1);
        stop = 1'b0;
        pulse(7, 10);
        chk("stop_T07", 32'(TPIDX), 7);

        // FAULT after MAX_ERR sequence errors; only CLR exits.
        do_clr();
        for (int k = 1; k <= 12; k++) pulse(k, 5);
        pulse(1, 5);
        for (int i = 0; i < 4; i++) begin
            pulse(3, 5);
            pulse(1, 5);
        end
        chk("fault_FAULT",  32'(FAULT),   1);
        chk("fault_ERRCNT", 32'(ERR_CNT), 4);
        chk("fault_MCT",    32'(MCT_CNT), 1);
        pulse(2, 5);
        gojam = 1'b1; tick(); gojam = 1'b0;
        chk("fault_hold", 32'(FAULT), 1);
        do_clr();
        chk("clr_FAULT",  32'(FAULT),   0);
        chk("clr_ERRCNT", 32'(ERR_CNT), 0);
        chk("clr_MCT",    32'(MCT_CNT), 0);
        pulse(1, 5);
        chk("clr_relock", 32'(LOCKED), 1);

        // GOJAM mid-round keeps errors and MCT count.
        pulse(3, 5);
        for (int k = 1; k <= 8; k++) pulse(k, 5);
        chk("gojam_pre_TPIDX", 32'(TPIDX), 8);
        gojam = 1'b1; tick(); gojam = 1'b0;
        chk("gojam_TPIDX",  32'(TPIDX),   0);
        chk("gojam_ERRCNT", 32'(ERR_CNT), 1);
        chk("gojam_SEQ",    32'(SEQ_ERR), 1);
        chk("gojam_MCT",    32'(MCT_CNT), 0);
        // CLR and GOJAM with an out-of-order edge in the same cycle.
        pulse(1, 5);
        clr = 1'b1; gojam = 1'b1; t_vec[5] = 1'b1;
        tick();
        clr = 1'b0; gojam = 1'b0; t_vec = '0;
        chk("clrgj_ERRCNT", 32'(ERR_CNT), 0);
        chk("clrgj_SEQ",    32'(SEQ_ERR), 0);
        chk("clrgj_LOCKED", 32'(LOCKED),  0);
        ticks(3);

        // Randomized traffic against the model.
        nxt = 1;
        for (int s = 0; s < 600; s++) begin
            r = $urandom_range(0, 99);
            stop = ($urandom_range(0, 9) == 0);
            if (r < 80) begin
                pulse(nxt, $urandom_range(1, 6));
                nxt = (nxt % 12) + 1;
            end else if (r < 88) begin
                pulse($urandom_range(1, 12), $urandom_range(1, 6));
            end else if (r < 93) begin
                a = $urandom_range(1, 12);
                b = $urandom_range(1, 12);
                pulse2(a, b, $urandom_range(1, 6));
            end else if (r < 96) begin
                gojam = 1'b1; tick(); gojam = 1'b0;
            end else if (r < 98) begin
                do_clr();
            end else begin
                ticks($urandom_range(150, 260));
            end
        end
        stop = 1'b0;
        ticks(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
